// File: rtl/pcpi_scheduler.sv
// PCPI scheduler: decodes picorv32 PCPI requests, dispatches to one of four coprocessors, returns a registered result.
// Optional dispatch statistics (stat_cnt/stat_clr) are built when PCPI_SCHED_STATS_EN is defined.
module pcpi_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [3:0]  SLAVE_EN       = 4'b1111
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pcpi_valid,
  input  logic [31:0]   pcpi_insn,
  input  logic [31:0]   pcpi_rs1,
  input  logic [31:0]   pcpi_rs2,
  output logic          pcpi_wr,
  output logic [31:0]   pcpi_rd,
  output logic          pcpi_wait,
  output logic          pcpi_ready,
  output logic [3:0]    slv_valid,
  output logic [31:0]   slv_insn,
  output logic [31:0]   slv_rs1,
  output logic [31:0]   slv_rs2,
  input  logic [3:0]    slv_wr,
  input  logic [127:0]  slv_rd,
  input  logic [3:0]    slv_wait,
  input  logic [3:0]    slv_ready,
  output logic          err_timeout
`ifdef PCPI_SCHED_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [63:0]   stat_cnt
`endif
);

  // state    | meaning
  // IDLE     | waiting for a decodable, enabled request
  // DISPATCH | first cycle of slave request, slave response ignored
  // WAIT     | slave request held, watchdog running
  // RESP     | one-cycle pcpi_ready with latched result
  // DONE     | request served or aborted, waiting for pcpi_valid low
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [1:0]  r_sel;
  logic [15:0] r_wd;
  logic        r_wr;
  logic [31:0] r_rd;
  logic [31:0] r_insn;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic        r_err;

  logic        w_match;
  logic [1:0]  w_sel;
  logic        w_hit;
  logic        w_req;
  logic        w_sel_ready;
  logic        w_sel_wr;
  logic [31:0] w_sel_rd;
  logic        w_unused_wait;

  always_comb begin
    w_match = 1'b0;
    w_sel   = 2'd0;
    if (pcpi_insn[6:0] == 7'b0110011 && pcpi_insn[31:25] == 7'b0000001) begin
      w_match = 1'b1;
      w_sel   = pcpi_insn[14] ? 2'd1 : 2'd0;
    end else if (pcpi_insn[6:0] == 7'b0001011) begin
      if (pcpi_insn[14:12] == 3'b000) begin
        w_match = 1'b1;
        w_sel   = 2'd2;
      end else if (pcpi_insn[14:12] == 3'b001) begin
        w_match = 1'b1;
        w_sel   = 2'd3;
      end
    end
  end

  assign w_hit       = w_match & SLAVE_EN[w_sel];
  assign w_sel_ready = slv_ready[r_sel];
  assign w_sel_wr    = slv_wr[r_sel];
  assign w_sel_rd    = slv_rd[{r_sel, 5'd0} +: 32];
  // slave wait lines are informational; the scheduler drives pcpi_wait itself
  assign w_unused_wait = ^slv_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_wd    <= 16'd0;
      r_wr    <= 1'b0;
      r_rd    <= 32'd0;
      r_insn  <= 32'd0;
      r_rs1   <= 32'd0;
      r_rs2   <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pcpi_valid && w_hit) begin
            r_state <= S_DISPATCH;
            r_sel   <= w_sel;
            r_insn  <= pcpi_insn;
            r_rs1   <= pcpi_rs1;
            r_rs2   <= pcpi_rs2;
            r_wd    <= 16'd0;
          end
        end
        S_DISPATCH: r_state <= pcpi_valid ? S_WAIT : S_IDLE;
        S_WAIT: begin
          if (r_wd != 16'hFFFF) r_wd <= r_wd + 16'd1;
          // ready takes priority over a same-cycle watchdog expiry
          if (!pcpi_valid) begin
            r_state <= S_IDLE;
          end else if (w_sel_ready) begin
            r_state <= S_RESP;
            r_wr    <= w_sel_wr;
            r_rd    <= w_sel_rd;
          end else if (r_wd == WD_LAST) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end
        end
        S_RESP: r_state <= S_DONE;
        S_DONE: if (!pcpi_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_req       = (r_state == S_DISPATCH) || (r_state == S_WAIT);
  assign slv_valid   = w_req ? (4'b0001 << r_sel) : 4'b0000;
  assign pcpi_wait   = w_req;
  assign pcpi_ready  = (r_state == S_RESP);
  assign pcpi_wr     = pcpi_ready & r_wr;
  assign pcpi_rd     = r_rd;
  assign slv_insn    = r_insn;
  assign slv_rs1     = r_rs1;
  assign slv_rs2     = r_rs2;
  assign err_timeout = r_err;

`ifdef PCPI_SCHED_STATS_EN
  logic [3:0][15:0] r_stat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat <= '0;
    end else if (stat_clr) begin
      r_stat <= '0;
    end else if (r_state == S_DISPATCH && r_stat[r_sel] != 16'hFFFF) begin
      r_stat[r_sel] <= r_stat[r_sel] + 16'd1;
    end
  end

  assign stat_cnt = r_stat;
`endif

endmodule

// File: tb/tb_pcpi_scheduler.sv
// Directed bench for pcpi_scheduler: dispatch, latency, timeout, abort, reset and optional stats.
module tb_pcpi_scheduler;

  localparam logic [31:0] INSN_MUL  = 32'h02B50533;
  localparam logic [31:0] INSN_DIVU = 32'h02B55533;
  localparam logic [31:0] INSN_C0   = 32'h0000000B;
  localparam logic [31:0] INSN_C1   = 32'h0000100B;
  localparam logic [31:0] INSN_UNK  = 32'h00B50533;

  logic         clk = 1'b0;
  logic         resetn;
  logic         pcpi_valid;
  logic [31:0]  pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic [3:0]   slv_wr, slv_wait, slv_ready;
  logic [127:0] slv_rd;

  logic         a_wr, a_wait, a_ready, a_err;
  logic [31:0]  a_rd, a_insn, a_rs1, a_rs2;
  logic [3:0]   a_valid;
  logic         b_wr, b_wait, b_ready, b_err;
  logic [31:0]  b_rd, b_insn, b_rs1, b_rs2;
  logic [3:0]   b_valid;
`ifdef PCPI_SCHED_STATS_EN
  logic         stat_clr;
  logic [63:0]  a_stat, b_stat;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcpi_scheduler #(.TIMEOUT_CYCLES(8), .SLAVE_EN(4'b1111)) u_dut_a (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(a_wr), .pcpi_rd(a_rd),
    .pcpi_wait(a_wait), .pcpi_ready(a_ready), .slv_valid(a_valid), .slv_insn(a_insn),
    .slv_rs1(a_rs1), .slv_rs2(a_rs2), .slv_wr(slv_wr), .slv_rd(slv_rd),
    .slv_wait(slv_wait), .slv_ready(slv_ready), .err_timeout(a_err)
`ifdef PCPI_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(a_stat)
`endif
  );

  pcpi_scheduler #(.TIMEOUT_CYCLES(8), .SLAVE_EN(4'b0111)) u_dut_b (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(b_wr), .pcpi_rd(b_rd),
    .pcpi_wait(b_wait), .pcpi_ready(b_ready), .slv_valid(b_valid), .slv_insn(b_insn),
    .slv_rs1(b_rs1), .slv_rs2(b_rs2), .slv_wr(slv_wr), .slv_rd(slv_rd),
    .slv_wait(slv_wait), .slv_ready(slv_ready), .err_timeout(b_err)
`ifdef PCPI_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(b_stat)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go_idle;
    pcpi_valid = 1'b0;
    slv_ready  = 4'b0000;
    tick;
    tick;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  n;
    logic bad;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    slv_wr     = 4'b0000;
    slv_wait   = 4'b0000;
    slv_ready  = 4'b0000;
    slv_rd     = '0;
`ifdef PCPI_SCHED_STATS_EN
    stat_clr   = 1'b0;
`endif
    #12;
    chk("rst_valid", a_valid, 0);
    chk("rst_wait", a_wait, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rd", a_rd, 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // MUL, slave 0 answers in its second WAIT cycle
    pcpi_valid = 1'b1; pcpi_insn = INSN_MUL; pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd6;
    slv_rd[31:0] = 32'd42; slv_wr = 4'b0001;
    tick;
    chk("mul_valid", a_valid, 4'b0001);
    chk("mul_wait", a_wait, 1);
    chk("mul_insn", a_insn, INSN_MUL);
    chk("mul_rs1", a_rs1, 7);
    chk("mul_rs2", a_rs2, 6);
    tick;
    tick;
    slv_ready = 4'b0001;
    tick;
    slv_ready = 4'b0000;
    chk("mul_ready", a_ready, 1);
    chk("mul_rd", a_rd, 42);
    chk("mul_wr", a_wr, 1);
    chk("mul_resp_valid", a_valid, 0);
    chk("mul_resp_wait", a_wait, 0);
    tick;
    chk("mul_done_ready", a_ready, 0);
    chk("mul_done_rd", a_rd, 42);
    tick;
    chk("mul_no_redispatch", a_valid, 0);
    go_idle;

    // DIVU with ready held from the start: ready in DISPATCH ignored, latency 3
    pcpi_valid = 1'b1; pcpi_insn = INSN_DIVU;
    slv_rd[63:32] = 32'h1234; slv_wr = 4'b0000; slv_ready = 4'b0010;
    tick;
    chk("divu_valid", a_valid, 4'b0010);
    n = 1;
    while (!a_ready && n < 10) begin
      tick;
      n++;
    end
    chk("divu_latency", n, 3);
    chk("divu_rd", a_rd, 32'h1234);
    chk("divu_wr", a_wr, 0);
    go_idle;

    // custom-0 funct3=001: slave 3, disabled in dut b
    pcpi_valid = 1'b1; pcpi_insn = INSN_C1; slv_rd[127:96] = 32'hCAFE; slv_wr = 4'b1000;
    tick;
    chk("c1_valid", a_valid, 4'b1000);
    chk("c1_dis_valid", b_valid, 0);
    chk("c1_dis_wait", b_wait, 0);
    tick;
    slv_ready = 4'b1000;
    tick;
    chk("c1_rd", a_rd, 32'hCAFE);
    chk("c1_dis_wait2", b_wait, 0);
    chk("c1_dis_ready", b_ready, 0);
    go_idle;

    // unknown instruction held 20 cycles
    pcpi_valid = 1'b1; pcpi_insn = INSN_UNK;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (a_valid != 4'b0000 || a_wait || a_ready) bad = 1'b1;
    end
    chk("unk_quiet", bad, 0);
    go_idle;

    // abort by pcpi_valid falling in WAIT, then again in DISPATCH
    pcpi_valid = 1'b1; pcpi_insn = INSN_MUL;
    tick;
    tick;
    pcpi_valid = 1'b0;
    tick;
    chk("abort_wait_valid", a_valid, 0);
    chk("abort_wait_ready", a_ready, 0);
    pcpi_valid = 1'b1;
    tick;
    chk("abort_redispatch", a_valid, 4'b0001);
    pcpi_valid = 1'b0;
    tick;
    chk("abort_disp_valid", a_valid, 0);
    go_idle;

    // stray slave1 ready ignored, slave0 ready on the watchdog-expiry cycle wins
    pcpi_valid = 1'b1; pcpi_insn = INSN_MUL; slv_rd[31:0] = 32'd77; slv_wr = 4'b0001;
    tick;
    tick;
    slv_ready = 4'b0010;
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (a_valid != 4'b0001 || a_ready) bad = 1'b1;
    end
    chk("stray_ready_ignored", bad, 0);
    slv_ready = 4'b0001;
    tick;
    chk("expiry_ready", a_ready, 1);
    chk("expiry_rd", a_rd, 77);
    chk("expiry_err", a_err, 0);
    go_idle;

    // slave 2 never answers: 8 WAIT cycles then abort
    pcpi_valid = 1'b1; pcpi_insn = INSN_C0;
    tick;
    chk("to_valid", a_valid, 4'b0100);
    n = 0;
    bad = 1'b0;
    tick;
    while (a_valid[2] && n < 30) begin
      n++;
      tick;
      if (a_ready) bad = 1'b1;
    end
    chk("to_wait_cycles", n, 8);
    chk("to_err", a_err, 1);
    chk("to_no_ready", bad, 0);
    chk("to_done_wait", a_wait, 0);
    go_idle;

    // asynchronous reset mid-transaction
    pcpi_valid = 1'b1; pcpi_insn = INSN_MUL;
    tick;
    tick;
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_wait", a_wait, 0);
    chk("arst_err", a_err, 0);
    chk("arst_rd", a_rd, 0);
    chk("arst_insn", a_insn, 0);
    pcpi_valid = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    tick;

`ifdef PCPI_SCHED_STATS_EN
    for (int i = 0; i < 3; i++) begin
      pcpi_valid = 1'b1; pcpi_insn = INSN_MUL;
      tick;
      pcpi_valid = 1'b0;
      tick;
    end
    chk("stat_mul", a_stat[15:0], 3);
    chk("stat_div", a_stat[31:16], 0);
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    chk("stat_clr", a_stat, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
